// File: rtl/mem_arbiter.sv
// Two-way arbiter sharing the 128-bit block memory port between icache and dcache.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces fixed dcache priority with alternating priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_mem_ready,
  output logic [DATA_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

  state_t state, state_nxt;
  logic   i_req, d_req, any_req, grant_d;

  assign i_req   = i_mem_read;
  assign d_req   = d_mem_read | d_mem_write;
  assign any_req = i_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_i = 1 when icache held the most recent grant; 0 after reset (dcache last)
  logic last_i;

  always_comb grant_d = d_req && (!i_req || last_i);

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      last_i <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_i <= !grant_d;
    end
  end
`else
  always_comb grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = grant_d ? BUSY_D : BUSY_I;
      BUSY_I:  if (mem_ready) state_nxt = RELEASE;
      BUSY_D:  if (mem_ready) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Downstream request registers: loaded at grant, frozen while busy, cleared on completion
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (grant_d) begin
              mem_read  <= d_mem_read & ~d_mem_write;
              mem_write <= d_mem_write;
              mem_addr  <= d_mem_addr;
              mem_wdata <= d_mem_wdata;
            end else begin
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              mem_addr  <= i_mem_addr;
              mem_wdata <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_mem_ready = mem_ready && (state == BUSY_I);
  assign d_mem_ready = mem_ready && (state == BUSY_D);
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule
